// File: rtl/sprite_line_fetcher.sv
// rtl/sprite_line_fetcher.sv - hblank sprite row prefetch into a line buffer with pixel-synchronous playback
//
// Purpose:
//   On each line_start that hits the sprite's vertical span, reads one sprite
//   row (SPR_W palette indices) from BRAM into an internal line buffer. During
//   active video the buffer is played out against h_cnt with one cycle latency.
//
// Ports:
//   clk, rst                 pixel clock, asynchronous active-high reset
//   line_start, next_v       hblank start pulse and the line it announces
//   spr_en, spr_x, spr_y     sprite visibility and position
//   h_cnt                    current horizontal pixel counter
//   bram_rd, bram_addr       BRAM read port (registered)
//   bram_dout                BRAM data, valid one cycle after bram_rd
//   color_index, opaque      registered pixel index and index != 0
//   busy                     fetch in progress (FETCH or DRAIN)
//   overrun                  one-cycle pulse when a fetch is aborted
module sprite_line_fetcher #(
    parameter int SPR_W  = 32,
    parameter int SPR_H  = 32,
    parameter int ADDR_W = 10,
    parameter int IDX_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              line_start,
    input  logic [9:0]        next_v,
    input  logic              spr_en,
    input  logic [9:0]        spr_x,
    input  logic [9:0]        spr_y,
    input  logic [9:0]        h_cnt,
    output logic              bram_rd,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [IDX_W-1:0]  bram_dout,
    output logic [IDX_W-1:0]  color_index,
    output logic              opaque,
    output logic              busy,
    output logic              overrun
);

    localparam int K_W   = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int ROW_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [K_W-1:0]     k_q, k_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic               line_valid_q, line_valid_d;
    logic               overrun_q, overrun_d;
    logic               bram_rd_q, bram_rd_d;
    logic [ADDR_W-1:0]  bram_addr_q, bram_addr_d;
    logic               rd_dly_q, rd_dly_d;
    logic [K_W-1:0]     k_dly_q, k_dly_d;
    logic [IDX_W-1:0]   color_q, color_d;
    logic               opaque_q, opaque_d;

    logic               hit;
    logic               abort;
    logic               wr_en;
    logic               in_x;
    logic [K_W-1:0]     col;

    logic [IDX_W-1:0]   line_buf [SPR_W];

    // Vertical hit test in 11 bits so a sprite near the bottom of the
    // 10-bit coordinate space never wraps around to the top lines.
    assign hit = spr_en
              && ({1'b0, next_v} >= {1'b0, spr_y})
              && ({1'b0, next_v} <  ({1'b0, spr_y} + 11'(SPR_H)));

    assign abort = line_start && (state_q != IDLE);

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        row_d        = row_q;
        line_valid_d = line_valid_q;
        overrun_d    = 1'b0;

        if (line_start) begin
            // A new line always invalidates the buffer; a pending fetch is
            // dropped and the new line is evaluated as if from IDLE.
            overrun_d    = (state_q != IDLE);
            line_valid_d = 1'b0;
            if (hit) begin
                state_d = FETCH;
                k_d     = '0;
                row_d   = ROW_W'(next_v - spr_y);
            end else begin
                state_d = IDLE;
            end
        end else begin
            case (state_q)
                FETCH: begin
                    k_d = k_q + 1'b1;
                    if (k_q == K_W'(SPR_W - 1)) begin
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    line_valid_d = 1'b1;
                    state_d      = IDLE;
                end
                default: begin
                end
            endcase
        end

        // Read port is registered from the next state so bram_rd is high
        // exactly during FETCH cycles and bram_addr tracks k in that cycle.
        bram_rd_d   = (state_d == FETCH);
        bram_addr_d = bram_rd_d ? (ADDR_W'(row_d * SPR_W) + ADDR_W'(k_d)) : bram_addr_q;

        // Data returns one cycle after the read; an abort kills both the write
        // landing this cycle and the one still in the BRAM pipeline.
        rd_dly_d = bram_rd_q && !abort;
        k_dly_d  = k_q;
    end

    assign wr_en = rd_dly_q && !abort;

    // Horizontal window in 11 bits: a sprite hanging off the right edge is
    // clipped, never wrapped onto the start of the next line.
    assign in_x = ({1'b0, h_cnt} >= {1'b0, spr_x})
               && ({1'b0, h_cnt} <  ({1'b0, spr_x} + 11'(SPR_W)));
    assign col  = K_W'(h_cnt - spr_x);

    always_comb begin
        color_d  = '0;
        if (line_valid_q && in_x) begin
            color_d = line_buf[col];
        end
        opaque_d = |color_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            k_q          <= '0;
            row_q        <= '0;
            line_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            bram_rd_q    <= 1'b0;
            bram_addr_q  <= '0;
            rd_dly_q     <= 1'b0;
            k_dly_q      <= '0;
            color_q      <= '0;
            opaque_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            row_q        <= row_d;
            line_valid_q <= line_valid_d;
            overrun_q    <= overrun_d;
            bram_rd_q    <= bram_rd_d;
            bram_addr_q  <= bram_addr_d;
            rd_dly_q     <= rd_dly_d;
            k_dly_q      <= k_dly_d;
            color_q      <= color_d;
            opaque_q     <= opaque_d;
        end
    end

    // Buffer contents are don't-care after reset; line_valid gates playback.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            line_buf[k_dly_q] <= bram_dout;
        end
    end

    assign bram_rd     = bram_rd_q;
    assign bram_addr   = bram_addr_q;
    assign color_index = color_q;
    assign opaque      = opaque_q;
    assign busy        = (state_q != IDLE);
    assign overrun     = overrun_q;

endmodule

// File: doc/sprite_line_fetcher.md
Name: sprite_line_fetcher

Overview:
- Scanline prefetch controller for the sprite palette-index BRAM.
- During each horizontal blank it fetches one sprite row of 3-bit palette indices into an internal line buffer.
- During active video it plays the buffered indices out in step with the pixel counter, to the colour decoder and the VGA transparency logic.
- It is the only BRAM reader, so BRAM reads and pixel output never collide.

Parameters:
- SPR_W, 32: sprite width in pixels; power of two.
- SPR_H, 32: sprite height in lines.
- ADDR_W, 10: BRAM address width; must satisfy 2^ADDR_W >= SPR_W*SPR_H.
- IDX_W, 3: palette index width; 0 = transparent.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous reset, active-high.
- line_start  in  1  one-cycle pulse at start of hblank announcing line next_v.
- next_v  in  10  vertical coordinate of the upcoming line.
- spr_en  in  1  sprite visible.
- spr_x  in  10  sprite left column.
- spr_y  in  10  sprite top row.
- h_cnt  in  10  current horizontal pixel counter.
- bram_rd  out  1  BRAM read enable.
- bram_addr  out  ADDR_W  BRAM read address.
- bram_dout  in  IDX_W  BRAM data; valid exactly 1 cycle after bram_rd.
- color_index  out  IDX_W  index for current pixel, to the decoder.
- opaque  out  1  color_index != 0.
- busy  out  1  fetch in progress.
- overrun  out  1  one-cycle pulse when a fetch is aborted.

Behaviour:
- Reset (async, immediate): state=IDLE, line_valid=0, bram_rd=0, bram_addr=0, color_index=0, opaque=0, busy=0, overrun=0, issue/write counters=0. Line buffer contents are don't-care.

State machine: IDLE, FETCH, DRAIN.
- IDLE, on line_start:
  - line_valid<=0.
  - If spr_en and spr_y <= next_v < spr_y+SPR_H, compare in 11 bits with no wrap: latch row=next_v-spr_y, k<=0, go FETCH.
  - Otherwise stay IDLE.
- FETCH:
  - Each cycle: bram_rd=1, bram_addr=row*SPR_W+k (row concatenated with k), k++.
  - After issuing k=SPR_W-1, go DRAIN.
- Write path: one cycle after each issue, line_buf[k_prev]<=bram_dout, using a 1-cycle delayed copy of k and bram_rd.
- DRAIN: one cycle for the final write; then line_valid<=1, go IDLE.
- busy=1 in FETCH and DRAIN.
- Fetch duration: SPR_W+1 cycles from the cycle after line_start to line_valid=1 (33 cycles at defaults), which fits within a 160-cycle hblank.

Abort:
- line_start while busy: overrun pulses for 1 cycle, line_valid stays 0, in-flight write discarded.
- Then the new line is evaluated exactly as from IDLE, in the same cycle.

Pixel output (registered, latency 1):
- On cycle t, if line_valid and spr_x <= h_cnt < spr_x+SPR_W (11-bit compare), color_index at t+1 = line_buf[h_cnt-spr_x]; otherwise 0.
- opaque registered alongside, from the same index.
- Output is 0 while busy, since line_valid=0.
- Sprite partially off the right edge (spr_x+SPR_W > 640): columns beyond h_cnt range are simply never shown; no wrap to column 0.
- Sprite rows with next_v beyond spr_y+SPR_H-1 yield no fetch. spr_y near 1023 must not wrap.
- spr_x/spr_y/spr_en changing mid-line: row is latched at line_start. spr_x is sampled live; upstream must change it only in vblank.
- bram_rd=0 whenever not in FETCH, and bram_addr holds its last value.

Test Plan:
- Reset mid-FETCH (assert rst at issue k=10) -> all outputs 0 immediately; next line_start with a hit fetches cleanly from k=0.
- BRAM preloaded with addr mod 6 → spr_en=1, spr_y=100, spr_x=200, line_start with next_v=103 -> bram_addr 96..127 on consecutive cycles; busy 33 cycles; then for h_cnt=200..231, color_index one cycle later = (96+h-200) mod 6; opaque=0 where index 0; outside 200..231, index 0.
- next_v=99, then next_v=132 (spr_y=100) -> no bram_rd, line_valid=0, color_index=0 for the whole line; next_v=131 -> fetch of row 31, addresses 992..1023.
- line_start at fetch cycle 5, next_v=104 -> overrun=1 for one cycle; fetch restarts at addr 128; final buffer holds row 4 only.
- spr_x=620 -> indices for h_cnt 620..639 = buffer[0..19]; h_cnt 0..11 of the next line output 0 (no wrap).
- spr_y=1010, next_v=5 -> no fetch (no 10-bit wrap); spr_en=0 with an in-range next_v -> no fetch, output 0.
